rv32_alu: RTL and testbench



---
 rtl/rv32_alu.sv | 101 ++++++++++
 tb/tb_rv32_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu.sv
// RV32I execute-stage ALU with a single registered result stage.
// Define ALU_BRCMP_EN to add the combinational branch-compare ports (br_un, br_eq, br_lt).
module rv32_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [3:0]  ALUsel,
`ifdef ALU_BRCMP_EN
   input  logic        br_un,
   output logic        br_eq,
   output logic        br_lt,
`endif
   output logic [31:0] alu_res,
   output logic        out_valid,
   output logic        zero
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned SHW  = 5;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_SLL   = 4'd2;
   localparam logic [3:0] OP_SLT   = 4'd3;
   localparam logic [3:0] OP_SLTU  = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_OR    = 4'd8;
   localparam logic [3:0] OP_AND   = 4'd9;
   localparam logic [3:0] OP_JADD  = 4'd10;
   localparam logic [3:0] OP_LUIOP = 4'd11;

   logic [XLEN-1:0] res_c;
   logic [XLEN-1:0] sum_c;
   logic [SHW-1:0]  shamt_c;

   logic [XLEN-1:0] alu_res_q, alu_res_d;
   logic            zero_q, zero_d;
   logic            out_valid_q, out_valid_d;

   assign shamt_c = rs2[SHW-1:0];
   assign sum_c   = rs1 + rs2;

   // Result datapath; reserved encodings yield zero.
   always_comb begin
      res_c = '0;
      case (ALUsel)
         OP_ADD:   res_c = sum_c;
         OP_SUB:   res_c = rs1 - rs2;
         OP_SLL:   res_c = rs1 << shamt_c;
         OP_SLT:   res_c = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
         OP_SLTU:  res_c = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
         OP_XOR:   res_c = rs1 ^ rs2;
         OP_SRL:   res_c = rs1 >> shamt_c;
         OP_SRA:   res_c = XLEN'($signed(rs1) >>> shamt_c);
         OP_OR:    res_c = rs1 | rs2;
         OP_AND:   res_c = rs1 & rs2;
         OP_JADD:  res_c = {sum_c[XLEN-1:1], 1'b0};
         OP_LUIOP: res_c = rs2;
         default:  res_c = '0;
      endcase
   end

   // Idle cycles hold the last result and flag but drop out_valid.
   always_comb begin
      alu_res_d   = alu_res_q;
      zero_d      = zero_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         alu_res_d   = res_c;
         zero_d      = (res_c == '0);
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_res_q   <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         alu_res_q   <= alu_res_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign alu_res   = alu_res_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;

`ifdef ALU_BRCMP_EN
   // Same-cycle compare for the branch unit, independent of reset.
   assign br_eq = (rs1 == rs2);
   assign br_lt = br_un ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
`endif

endmodule

// File: tb/tb_rv32_alu.sv
// Scoreboard bench for rv32_alu: directed cases plus randomized traffic against a behavioural model.
module tb_rv32_alu;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [3:0]  ALUsel;
   logic [31:0] alu_res;
   logic        out_valid;
   logic        zero;
`ifdef ALU_BRCMP_EN
   logic        br_un;
   logic        br_eq;
   logic        br_lt;
`endif

   rv32_alu dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .rs1       (rs1),
      .rs2       (rs2),
      .ALUsel    (ALUsel),
`ifdef ALU_BRCMP_EN
      .br_un     (br_un),
      .br_eq     (br_eq),
      .br_lt     (br_lt),
`endif
      .alu_res   (alu_res),
      .out_valid (out_valid),
      .zero      (zero)
   );

   typedef struct packed {
      logic        v;
      logic [31:0] r;
      logic        z;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_res;
   logic        m_zero;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, required finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%08h required=%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model from the instruction semantics, using 64-bit arithmetic.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ua  = {32'd0, a};
      longint unsigned ub  = {32'd0, b};
      longint unsigned pw  = 64'd1 << b[4:0];
      longint          sa  = longint'(int'(a));
      longint          sb_ = longint'(int'(b));
      longint          q;
      case (op)
         4'd0:  return 32'(ua + ub);
         4'd1:  return 32'(ua + 64'h1_0000_0000 - ub);
         4'd2:  return 32'(ua * pw);
         4'd3:  return (sa < sb_) ? 32'd1 : 32'd0;
         4'd4:  return (ua < ub) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return 32'(ua / pw);
         4'd7: begin
            q = (sa >= 0) ? (sa / longint'(pw)) : ((sa - longint'(pw) + 1) / longint'(pw));
            return 32'(q);
         end
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return 32'((ua + ub) % 64'h1_0000_0000) & 32'hFFFF_FFFE;
         4'd11: return b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive(input logic rst, input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      reset    = rst;
      in_valid = v;
      ALUsel   = op;
      rs1      = a;
      rs2      = b;
   endtask

   // Issue using the model for the expected result.
   task automatic issue(input logic rst, input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      drive(rst, v, op, a, b);
      if (rst) begin
         m_res  = 32'd0;
         m_zero = 1'b1;
         e.v    = 1'b0;
      end else if (v) begin
         m_res  = ref_alu(op, a, b);
         m_zero = (m_res == 32'd0);
         e.v    = 1'b1;
      end else begin
         e.v    = 1'b0;
      end
      e.r = m_res;
      e.z = m_zero;
      sb.push_back(e);
   endtask

   // Issue a valid op with a hand-computed expected result.
   task automatic issue_lit(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want);
      exp_t e;
      drive(1'b0, 1'b1, op, a, b);
      m_res  = want;
      m_zero = (want == 32'd0);
      e.v    = 1'b1;
      e.r    = want;
      e.z    = m_zero;
      sb.push_back(e);
   endtask

   // Monitor: pops one expectation per clock edge and compares.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
            chk("alu_res",   alu_res,            e.r);
            chk("zero",      {31'd0, zero},      {31'd0, e.z});
         end
      end
   end

   initial begin
      exp_t e0;
      logic [3:0]  op;
      logic [31:0] a, b;
      reset    = 1'b1;
      in_valid = 1'b0;
      ALUsel   = 4'd0;
      rs1      = 32'd0;
      rs2      = 32'd0;
`ifdef ALU_BRCMP_EN
      br_un    = 1'b0;
`endif
      m_res  = 32'd0;
      m_zero = 1'b1;
      e0.v = 1'b0; e0.r = 32'd0; e0.z = 1'b1;
      sb.push_back(e0);

      // Reset dominates a valid ADD, then the same ADD completes.
      issue(1'b1, 1'b1, 4'd0, 32'd5, 32'd7);
      issue_lit(4'd0, 32'd5, 32'd7, 32'd12);
      issue_lit(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
      issue_lit(4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
      issue_lit(4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
      issue_lit(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
      issue_lit(4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000);
      issue_lit(4'd6, 32'h8000_0000, 32'h24, 32'h0800_0000);
      issue_lit(4'd2, 32'd1, 32'd31, 32'h8000_0000);
      issue_lit(4'd10, 32'h1001, 32'h4, 32'h1004);
      issue_lit(4'd11, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);
      issue(1'b0, 1'b0, 4'd0, 32'd9, 32'd9);
      issue_lit(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
      issue_lit(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
      issue(1'b0, 1'b0, 4'd5, 32'd1, 32'd2);
      issue(1'b0, 1'b0, 4'd5, 32'd1, 32'd2);

`ifdef ALU_BRCMP_EN
      drive(1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1);
      br_un = 1'b0; #1;
      chk("br_lt_signed",   {31'd0, br_lt}, 32'd1);
      chk("br_eq_ne",       {31'd0, br_eq}, 32'd0);
      br_un = 1'b1; #1;
      chk("br_lt_unsigned", {31'd0, br_lt}, 32'd0);
      rs1 = 32'd7; rs2 = 32'd7; #1;
      chk("br_eq_eq",       {31'd0, br_eq}, 32'd1);
      e0.v = 1'b0; e0.r = m_res; e0.z = m_zero;
      sb.push_back(e0);
`endif

      // Randomized traffic with sparse reset and idle cycles.
      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
         if ($urandom_range(0, 7) == 0) a = b;
         issue(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), op, a, b);
`ifdef ALU_BRCMP_EN
         br_un = 1'($urandom_range(0, 1));
         #1;
         chk("br_eq_rand", {31'd0, br_eq}, {31'd0, (a == b)});
         chk("br_lt_rand", {31'd0, br_lt},
             {31'd0, (br_un ? ({32'd0, a} < {32'd0, b}) : (int'(a) < int'(b)))});
`endif
      end
      issue(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
